// File: rtl/regfile_pkg.sv
// Shared widths, queue entry type and arbitration priority for the
// register-file writeback path.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic {
        PRIO_MEM = 1'b0,
        PRIO_ALU = 1'b1
    } prio_e;

    function automatic prio_e flip_prio(input prio_e p);
        return (p == PRIO_MEM) ? PRIO_ALU : PRIO_MEM;
    endfunction

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Writeback queue storage: up to two pushes (slot A then slot B) and one pop
// per cycle, with the raw slots exposed so the top can search pending writes.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_push_a,
    input  wb_entry_t              i_entry_a,
    input  logic                   i_push_b,
    input  wb_entry_t              i_entry_b,
    input  logic                   i_pop,
    output wb_entry_t [DEPTH-1:0]  o_slots,
    output logic [PTR_W-1:0]       o_rd_ptr,
    output logic [CNT_W-1:0]       o_count
);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    wb_entry_t [DEPTH-1:0] r_slots;

    logic                  w_do_pop;
    logic                  w_push_b;
    logic [CNT_W-1:0]      w_push_n;
    logic [PTR_W-1:0]      w_wr_ptr_b;

    // Slot B is only meaningful alongside slot A, so entries stay contiguous.
    assign w_do_pop   = i_pop && (r_count != '0);
    assign w_push_b   = i_push_a && i_push_b;
    assign w_push_n   = CNT_W'(i_push_a) + CNT_W'(w_push_b);
    assign w_wr_ptr_b = r_wr_ptr + PTR_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + w_push_n - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (i_push_a) begin
            r_slots[r_wr_ptr] <= i_entry_a;
        end
        if (w_push_b) begin
            r_slots[w_wr_ptr_b] <= i_entry_b;
        end
    end

    assign o_slots  = r_slots;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results into one register-file write port through a
// small queue; define WB_BYPASS_EN to enable pending-write lookup forwarding.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  wsign,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] look_addr1,
    input  logic [REG_ADDR_W-1:0] look_addr2,
    output logic                  look_hit1,
    output logic                  look_hit2,
    output logic [DATA_W-1:0]     look_data1,
    output logic [DATA_W-1:0]     look_data2,
    output logic                  busy
);

    prio_e                 r_prio;
    prio_e                 w_prio_next;

    wb_entry_t [DEPTH-1:0] w_slots;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W-1:0]      w_free;
    logic                  w_busy;
    wb_entry_t             w_head;

    logic                  w_alu_fire;
    logic                  w_mem_fire;
    logic                  w_alu_push;
    logic                  w_mem_push;
    logic                  w_push_a;
    logic                  w_push_b;
    wb_entry_t             w_entry_a;
    wb_entry_t             w_entry_b;

    assign w_free = CNT_W'(DEPTH) - w_count;
    assign w_busy = (w_count != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prio <= PRIO_MEM;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    // Priority only matters for the last free slot; hand it over once used.
    always_comb begin
        w_prio_next = r_prio;
        if (w_free == CNT_W'(1)) begin
            if ((r_prio == PRIO_MEM && w_mem_fire) || (r_prio == PRIO_ALU && w_alu_fire)) begin
                w_prio_next = flip_prio(r_prio);
            end
        end
    end

    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (w_free >= CNT_W'(2)) begin
            alu_ready = 1'b1;
            mem_ready = 1'b1;
        end else if (w_free == CNT_W'(1)) begin
            alu_ready = (r_prio == PRIO_ALU);
            mem_ready = (r_prio == PRIO_MEM);
        end
    end

    assign w_alu_fire = alu_valid && alu_ready;
    assign w_mem_fire = mem_valid && mem_ready;
    assign w_alu_push = w_alu_fire && (alu_addr != '0);
    assign w_mem_push = w_mem_fire && (mem_addr != '0);

    // The load result always takes the older slot when both arrive together.
    assign w_push_a  = w_mem_push || w_alu_push;
    assign w_push_b  = w_mem_push && w_alu_push;
    assign w_entry_a = w_mem_push ? '{addr: mem_addr, data: mem_data}
                                  : '{addr: alu_addr, data: alu_data};
    assign w_entry_b = '{addr: alu_addr, data: alu_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_push_a  (w_push_a),
        .i_entry_a (w_entry_a),
        .i_push_b  (w_push_b),
        .i_entry_b (w_entry_b),
        .i_pop     (w_busy),
        .o_slots   (w_slots),
        .o_rd_ptr  (w_rd_ptr),
        .o_count   (w_count)
    );

    assign w_head = w_slots[w_rd_ptr];
    assign busy   = w_busy;
    assign wsign  = w_busy;
    assign waddr  = w_busy ? w_head.addr : '0;
    assign wdata  = w_busy ? w_head.data : '0;

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the last match is the value software sees.
    always_comb begin
        look_hit1  = 1'b0;
        look_hit2  = 1'b0;
        look_data1 = '0;
        look_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < w_count) begin
                if (look_addr1 != '0 && w_slots[w_rd_ptr + PTR_W'(k)].addr == look_addr1) begin
                    look_hit1  = 1'b1;
                    look_data1 = w_slots[w_rd_ptr + PTR_W'(k)].data;
                end
                if (look_addr2 != '0 && w_slots[w_rd_ptr + PTR_W'(k)].addr == look_addr2) begin
                    look_hit2  = 1'b1;
                    look_data2 = w_slots[w_rd_ptr + PTR_W'(k)].data;
                end
            end
        end
    end
`else
    logic w_unused_look;
    assign w_unused_look = ^{look_addr1, look_addr2};
    assign look_hit1  = 1'b0;
    assign look_hit2  = 1'b0;
    assign look_data1 = '0;
    assign look_data2 = '0;
`endif

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 clock  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 alu_valid / alu_ready  in / out  1 / 1  ALU result handshake.
REQ-005 alu_addr / alu_data  in / in  5 / 32  ALU destination register and value.
REQ-006 mem_valid / mem_ready  in / out  1 / 1  load-result handshake.
REQ-007 mem_addr / mem_data  in / in  5 / 32  load destination register and value.
REQ-008 wsign / waddr / wdata  out / out / out  1 / 5 / 32  register-file write port.
REQ-009 look_addr1 / look_addr2  in / in  5 / 5  pending-write lookup addresses.
REQ-010 look_hit1 / look_hit2 / look_data1 / look_data2  out  1 / 1 / 32 / 32  lookup results.
REQ-011 busy  out  1  queue non-empty.

Function
REQ-012 Transfer on a source SHALL occur at a rising edge where valid and ready are both 1.
REQ-013 Ready SHALL depend only on internal state: free >= 2 gives both ready; free == 1 gives ready only to the source named by prio; free == 0 gives neither.
REQ-014 prio SHALL toggle after every edge on which free == 1 and the favoured source transfers.
REQ-015 Both sources transferring on the same edge SHALL enqueue the mem entry ahead of the alu entry.
REQ-016 A transfer with addr == 0 SHALL be consumed (handshake completes) but not enqueued.
REQ-017 wsign SHALL equal busy, and waddr/wdata SHALL show the queue head, combinationally from registered state.
REQ-018 The head SHALL be popped on every edge with busy == 1; the write lands in the register file on that edge.
REQ-019 Latency: an entry accepted into an empty queue at edge N SHALL be written at edge N+1.
REQ-020 Pop and push on the same edge SHALL be legal, including at full (pop frees the slot for the next cycle only; ready is computed before pop).
REQ-021 Pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH or underflow.
REQ-022 With wsign == 0, waddr and wdata SHALL be 0.

Reset
REQ-023 Asserting reset_n low SHALL immediately clear pointers and count, set prio to mem, and discard queued entries.
REQ-024 During reset, wsign, busy, and all look_hit/look_data outputs SHALL be 0; both ready outputs SHALL be 1.
REQ-025 Reset mid-operation SHALL drop pending writes with no partial write emitted.
REQ-026 Deassertion is assumed synchronous to clock; the first transfer may occur on the first edge after release.

Configuration
REQ-027 With WB_BYPASS_EN defined, look_hitK SHALL be 1 if any queued entry (including the head) has addr == look_addrK != 0.
REQ-028 With WB_BYPASS_EN defined, look_dataK SHALL carry the youngest matching entry's data; it SHALL be 0 on a miss.
REQ-029 Without WB_BYPASS_EN, the lookup ports SHALL remain present and the look_* outputs SHALL be tied to 0.

Structure
REQ-030 Package regfile_pkg SHALL hold REG_ADDR_W=5, DATA_W=32 and the wb_entry_t {addr, data} typedef.
REQ-031 Queue storage and pointers SHALL live in sub-module wb_fifo (2-push/1-pop); arbitration, r0 filtering and lookup stay in the top level.

Verification
REQ-032 Single ALU write (addr 5, data 0xDEADBEEF) into an empty queue -> wsign=1, waddr=5, wdata=0xDEADBEEF for exactly the next cycle.
REQ-033 Simultaneous mem (3, 0x11) and alu (3, 0x22) -> writes in order 0x11 then 0x22 on consecutive cycles; look_data for addr 3 returns 0x22 while both are queued.
REQ-034 alu addr 0, data 0xFFFFFFFF -> alu_ready handshake completes, busy remains 0, and no wsign occurs.
REQ-035 Both sources held valid until the queue reaches free == 1 -> ready alternates between mem and alu, with no source starved over 8 cycles.
REQ-036 DEPTH=4, queue filled, then reset_n pulsed low mid-cycle -> wsign falls immediately, no further writes occur, and both readies are 1.
REQ-037 Build without WB_BYPASS_EN, queue holds addr 7 -> look_hit1=0 and look_data1=0 for look_addr1=7.
